enigma_stream_ctrl: RTL and testbench
=====================================

Name: enigma_stream_ctrl

Overview:
Byte-stream front end for the enigma cipher core. It accepts ASCII bytes through a valid/ready handshake and buffers them in a small FIFO. Each letter is translated to a 0–25 index and issued to the rotor/reflector chain as a single-cycle valid pulse. The controller waits for the core's done pulse, converts the result back to ASCII, and emits it downstream in order; non-letters bypass the core unchanged.

Parameters:
DEPTH, 4, input FIFO entries; power of two, minimum 2
TIMEOUT, 64, maximum cycles in WAIT before the core is declared hung; minimum 2

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  upstream byte valid
in_data  in  8  upstream ASCII byte
in_dec  in  1  decrypt flag, stored alongside each byte
in_ready  out  1  FIFO can accept; equals !full
core_valid  out  1  one-cycle issue pulse to the cipher core
core_din  out  8  letter index, 0–25
core_dec  out  1  decrypt flag of the issued character
core_done  in  1  one-cycle completion pulse from the core
core_dout  in  8  result index from the core
out_valid  out  1  output byte valid
out_data  out  8  output ASCII byte
out_ready  in  1  downstream accept
busy  out  1  FSM not in IDLE, or FIFO not empty
err_timeout  out  1  sticky: the core failed to respond within TIMEOUT cycles
err_range  out  1  sticky: the core returned an index greater than 25

Behaviour:
- Reset (asynchronous, active-high): FIFO empties, FSM goes to IDLE, timeout counter clears. All outputs are 0, except in_ready=1 once reset is released.
- FIFO
  - Each entry is 9 bits: {in_dec, in_data}.
  - A push occurs when in_valid && in_ready.
  - When full, in_ready=0 even if a pop happens in the same cycle.
  - A byte pushed while the FIFO is empty is visible to the FSM on the next cycle.
- FSM states: IDLE, ISSUE, WAIT, EMIT.
- IDLE
  - If the FIFO is not empty: pop the head into cur_byte/cur_dec.
  - A letter is 0x41–0x5A. For a letter, go to ISSUE; otherwise go to EMIT with out_data=cur_byte.
- ISSUE
  - Drive core_valid=1, core_din=cur_byte-0x41, core_dec=cur_dec for exactly one cycle.
  - Then go to WAIT with the timeout counter at 0.
- WAIT
  - core_dec is held.
  - On core_done:
    - If core_dout ≤ 25, result = 0x41 + core_dout.
    - Otherwise result = 0x3F and err_range is set.
    - Go to EMIT.
  - With no done, the counter increments. When the counter equals TIMEOUT-1 and no done is present: result = 0x3F, err_timeout is set, go to EMIT.
  - If done and the timeout occur in the same cycle, done wins.
- EMIT
  - out_valid=1 and out_data is held stable until out_ready.
  - On the handshake, return to IDLE. The next pop can occur in the following cycle.
- Latency
  - Bypass byte: pushed in cycle t, out_valid in cycle t+2.
  - Letter: core_valid in cycle t+2; out_valid in the cycle after core_done.
- core_done pulses received outside WAIT are ignored; no error is raised. This covers late responses after a timeout or a reset.
- Error flags clear only on reset.
- Ordering is strictly FIFO; only one character is in flight in the core at a time.

Optional Feature:
LOWER_CASE_EN
- Defined: bytes 0x61–0x7A are also enciphered, with index = byte-0x61. The case flag is stored with the character, and the output uses 0x61 + core_dout.
- Undefined: lowercase bytes take the bypass path unchanged.

Decomposition:
- Package enigma_stream_pkg holds:
  - the FSM state enum;
  - ASCII constants: 0x41 A_BASE, 0x61 a_BASE, 0x3F ERR_CHAR;
  - ALPHA_LEN=26;
  - the is_upper/is_lower helper functions.
- One sub-module, enigma_byte_fifo: a synchronous DEPTH×9 FIFO with full/empty flags and a count.

Test Plan:
1. Push 0x41 with dec=0; core model returns core_dout=7 three cycles after core_valid → out_data=0x48. core_din=0, core_dec=0, core_valid high for exactly one cycle.
2. Push 0x20 → out_valid at t+2 with out_data=0x20; core_valid never asserts.
3. Hold out_ready=0 and push 0x42, 0x43, …, with the core responding immediately → in_ready drops after DEPTH+1 bytes have been accepted (one in the FSM, DEPTH in the FIFO). Releasing out_ready produces the outputs in order with no loss.
4. Core never responds → exactly TIMEOUT cycles in WAIT, then out_data=0x3F and err_timeout=1. A core_done injected afterwards causes no extra output.
5. Core returns core_dout=30 → out_data=0x3F, err_range=1; a subsequent valid character is processed normally and the flag stays set.
6. Assert reset during WAIT → all outputs are 0 immediately and the FIFO is empty. A core_done one cycle after release is ignored, and a new byte is processed normally.

Source files
------------

// File: rtl/enigma_stream_pkg.sv
// Shared types and ASCII constants for the enigma byte-stream front end.
package enigma_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_EMIT
  } state_t;

  localparam logic [7:0]  A_BASE    = 8'h41;
  localparam logic [7:0]  a_BASE    = 8'h61;
  localparam logic [7:0]  ERR_CHAR  = 8'h3F;
  localparam int unsigned ALPHA_LEN = 26;

  function automatic logic is_upper(input logic [7:0] b);
    return (b >= A_BASE) && (b < (A_BASE + 8'(ALPHA_LEN)));
  endfunction

  function automatic logic is_lower(input logic [7:0] b);
    return (b >= a_BASE) && (b < (a_BASE + 8'(ALPHA_LEN)));
  endfunction

endpackage

// File: rtl/enigma_stream_ctrl_if.sv
// Handshake bundle for the stream controller: upstream bytes, cipher core
// issue/return, and downstream bytes. The controller takes the slave view.
interface enigma_stream_ctrl_if;

  logic       in_valid;
  logic [7:0] in_data;
  logic       in_dec;
  logic       in_ready;

  logic       core_valid;
  logic [7:0] core_din;
  logic       core_dec;
  logic       core_done;
  logic [7:0] core_dout;

  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;

  modport slave (
    input  in_valid, in_data, in_dec,
    output in_ready,
    output core_valid, core_din, core_dec,
    input  core_done, core_dout,
    output out_valid, out_data,
    input  out_ready
  );

  modport master (
    output in_valid, in_data, in_dec,
    input  in_ready,
    input  core_valid, core_din, core_dec,
    output core_done, core_dout,
    input  out_valid, out_data,
    output out_ready
  );

endinterface

// File: rtl/enigma_byte_fifo.sv
// Synchronous DEPTH x WIDTH FIFO with full/empty flags and an occupancy count.
// The head entry is presented combinationally on rdata.
module enigma_byte_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 9
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage array: written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers and occupancy; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/enigma_stream_ctrl.sv
// Byte-stream front end for the enigma cipher core. Bytes are buffered,
// letters are sent to the core one at a time as 0-25 indices, results are
// converted back to ASCII and emitted in order; other bytes pass through.
// Optional: define LOWER_CASE_EN to also encipher 'a'-'z' (case preserved).
module enigma_stream_ctrl
  import enigma_stream_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  enigma_stream_ctrl_if.slave  bus,
  output logic                 busy,
  output logic                 err_timeout,
  output logic                 err_range
);

  localparam int unsigned CW = $clog2(TIMEOUT);

  logic [8:0]              fifo_head;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [$clog2(DEPTH):0]  fifo_count;
  logic                    fifo_pop;
  logic [7:0]              head_byte;
  logic                    head_letter;
  logic [7:0]              head_base;

  state_t      state, state_d;
  logic [7:0]  cur_byte, cur_byte_d;
  logic        cur_dec, cur_dec_d;
  logic [7:0]  cur_base, cur_base_d;
  logic [7:0]  result, result_d;
  logic [CW-1:0] cnt, cnt_d;
  logic        err_timeout_d;
  logic        err_range_d;

  // in_ready is forced low while reset is held so all outputs read 0.
  assign bus.in_ready = !fifo_full && !reset;

  enigma_byte_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (9)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bus.in_valid && bus.in_ready),
    .wdata ({bus.in_dec, bus.in_data}),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign head_byte = fifo_head[7:0];

`ifdef LOWER_CASE_EN
  assign head_letter = is_upper(head_byte) || is_lower(head_byte);
  assign head_base   = is_lower(head_byte) ? a_BASE : A_BASE;
`else
  assign head_letter = is_upper(head_byte);
  assign head_base   = A_BASE;
`endif

  assign busy = (state != ST_IDLE) || (fifo_count != '0);

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      cur_byte    <= '0;
      cur_dec     <= 1'b0;
      cur_base    <= A_BASE;
      result      <= '0;
      cnt         <= '0;
      err_timeout <= 1'b0;
      err_range   <= 1'b0;
    end else begin
      state       <= state_d;
      cur_byte    <= cur_byte_d;
      cur_dec     <= cur_dec_d;
      cur_base    <= cur_base_d;
      result      <= result_d;
      cnt         <= cnt_d;
      err_timeout <= err_timeout_d;
      err_range   <= err_range_d;
    end
  end

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_d        = state;
    cur_byte_d     = cur_byte;
    cur_dec_d      = cur_dec;
    cur_base_d     = cur_base;
    result_d       = result;
    cnt_d          = cnt;
    err_timeout_d  = err_timeout;
    err_range_d    = err_range;
    fifo_pop       = 1'b0;
    bus.core_valid = 1'b0;
    bus.core_din   = '0;
    bus.core_dec   = 1'b0;
    bus.out_valid  = 1'b0;
    bus.out_data   = '0;

    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          cur_byte_d = head_byte;
          cur_dec_d  = fifo_head[8];
          cur_base_d = head_base;
          // Bypass bytes are emitted as-is, so preload them as the result.
          result_d   = head_byte;
          state_d    = head_letter ? ST_ISSUE : ST_EMIT;
        end
      end
      ST_ISSUE: begin
        bus.core_valid = 1'b1;
        bus.core_din   = cur_byte - cur_base;
        bus.core_dec   = cur_dec;
        cnt_d          = '0;
        state_d        = ST_WAIT;
      end
      ST_WAIT: begin
        bus.core_dec = cur_dec;
        if (bus.core_done) begin
          if (bus.core_dout < 8'(ALPHA_LEN)) begin
            result_d = cur_base + bus.core_dout;
          end else begin
            result_d    = ERR_CHAR;
            err_range_d = 1'b1;
          end
          state_d = ST_EMIT;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          result_d      = ERR_CHAR;
          err_timeout_d = 1'b1;
          state_d       = ST_EMIT;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      ST_EMIT: begin
        bus.out_valid = 1'b1;
        bus.out_data  = result;
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_enigma_stream_ctrl.sv
// Self-checking bench for enigma_stream_ctrl: directed scenarios followed by
// random byte streams, scored against an ASCII-level reference model.
module tb_enigma_stream_ctrl;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 20;
  localparam int unsigned QN      = 1024;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  logic err_timeout;
  logic err_range;

  enigma_stream_ctrl_if bus ();

  enigma_stream_ctrl #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .busy        (busy),
    .err_timeout (err_timeout),
    .err_range   (err_range)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Core model knobs.
  int  core_lat      = 1;
  bit  core_mute     = 1'b0;
  int  core_override = -1;
  int  ready_mode    = 0;

  // Expected outputs and expected core issues, in order.
  logic [7:0]  exp_mem [QN];
  int unsigned exp_wr = 0, exp_rd = 0;
  logic [8:0]  iss_mem [QN];
  int unsigned iss_wr = 0, iss_rd = 0;

  int cv_cycles = 0, cv_cyc = 0, done_cyc = 0, ov_rise_cyc = 0;
  int out_count = 0, push_cyc = 0;
  int inj_req_cnt = 0, inj_seen = 0;
  logic [7:0] inj_dout = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit letter_base(input logic [7:0] b, output logic [7:0] base);
    base = 8'h41;
    if (b >= "A" && b <= "Z") return 1'b1;
`ifdef LOWER_CASE_EN
    if (b >= "a" && b <= "z") begin
      base = 8'h61;
      return 1'b1;
    end
`endif
    return 1'b0;
  endfunction

  // Core substitution used by the model core: shift by 3, inverse for decrypt.
  function automatic int core_map(input int idx, input logic dec);
    return dec ? (idx + 23) % 26 : (idx + 3) % 26;
  endfunction

  // What the stream must emit for byte b under the current core behaviour.
  function automatic logic [7:0] ref_out(input logic [7:0] b, input logic dec);
    logic [7:0] base;
    int r;
    if (!letter_base(b, base)) return b;
    if (core_mute) return 8'h3F;
    r = (core_override >= 0) ? core_override : core_map(int'(b - base), dec);
    if (r > 25) return 8'h3F;
    return base + 8'(r);
  endfunction

  task automatic expect_push(input logic [7:0] b, input logic dec);
    logic [7:0] base;
    push_cyc = cyc;
    exp_mem[exp_wr % QN] = ref_out(b, dec);
    exp_wr++;
    if (letter_base(b, base)) begin
      iss_mem[iss_wr % QN] = {dec, 8'(b - base)};
      iss_wr++;
    end
  endtask

  // Starts and ends just after a falling edge.
  task automatic push_byte(input logic [7:0] b, input logic dec, input int max_wait);
    bit ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    bus.in_dec   = dec;
    for (int i = 0; i < max_wait && !ok; i++) begin
      #4;
      if (bus.in_ready) begin
        ok = 1'b1;
        expect_push(b, dec);
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("push_accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_drain(input int max_wait);
    bit done = 1'b0;
    for (int i = 0; i < max_wait && !done; i++) begin
      #4;
      if (exp_wr == exp_rd && !busy) done = 1'b1;
      @(negedge clk);
    end
    check("drain", exp_wr - exp_rd, 32'd0);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Model cipher core: answers each issue after core_lat cycles.
  task automatic core_model();
    int cd = 0;
    logic [7:0] resp = '0;
    logic cap_dec = 1'b0;
    bus.core_done = 1'b0;
    bus.core_dout = '0;
    forever begin
      @(negedge clk);
      bus.core_done = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          bus.core_done = 1'b1;
          bus.core_dout = resp;
          done_cyc      = cyc;
        end
      end
      if (inj_req_cnt != inj_seen) begin
        inj_seen      = inj_req_cnt;
        bus.core_done = 1'b1;
        bus.core_dout = inj_dout;
      end
      #4;
      if (reset) begin
        cd     = 0;
        iss_rd = iss_wr;
      end else if (bus.core_valid) begin
        cv_cycles++;
        cv_cyc  = cyc;
        cap_dec = bus.core_dec;
        if (iss_rd == iss_wr)
          check("core_spurious", {23'd0, bus.core_dec, bus.core_din}, 32'hFFFF_FFFF);
        else begin
          check("core_issue", {23'd0, bus.core_dec, bus.core_din}, {23'd0, iss_mem[iss_rd % QN]});
          iss_rd++;
        end
        if (!core_mute) begin
          cd   = core_lat;
          resp = (core_override >= 0) ? 8'(core_override)
                                      : 8'(core_map(int'(bus.core_din), bus.core_dec));
        end
      end else if (cd > 0) begin
        check("core_dec_hold", 32'(bus.core_dec), 32'(cap_dec));
      end
    end
  endtask

  // Downstream monitor: order, content and hold-while-stalled.
  task automatic out_monitor();
    bit prev_stall = 1'b0;
    bit prev_ov = 1'b0;
    logic [7:0] prev_data = '0;
    forever begin
      @(negedge clk);
      #4;
      if (reset) begin
        exp_rd     = exp_wr;
        prev_stall = 1'b0;
        prev_ov    = 1'b0;
      end else begin
        if (bus.out_valid && !prev_ov) ov_rise_cyc = cyc;
        if (bus.out_valid && prev_stall) check("out_hold", 32'(bus.out_data), 32'(prev_data));
        if (bus.out_valid && bus.out_ready) begin
          out_count++;
          if (exp_rd == exp_wr) check("out_spurious", 32'(bus.out_data), 32'hFFFF_FFFF);
          else begin
            check("out_data", 32'(bus.out_data), 32'(exp_mem[exp_rd % QN]));
            exp_rd++;
          end
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_data  = bus.out_data;
        prev_ov    = bus.out_valid;
      end
    end
  endtask

  task automatic ready_driver();
    bus.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       bus.out_ready = 1'b0;
        1:       bus.out_ready = 1'b1;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  endtask

  initial begin
    int cvb, oc, acc;
    logic [7:0] b;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_dec   = 1'b0;
    fork
      core_model();
      out_monitor();
      ready_driver();
    join_none

    // Reset state.
    idle_cycles(3);
    #1;
    check("reset_in_ready_low", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #4;
    check("reset_outs", {bus.in_ready, bus.out_valid, bus.core_valid, busy, err_timeout, err_range},
          6'b100000);
    @(negedge clk);

    // 1: single letter, core answers 7 three cycles after issue.
    ready_mode = 1; core_lat = 3; core_override = 7;
    idle_cycles(2);
    cvb = cv_cycles;
    push_byte(8'h41, 1'b0, 20);
    wait_drain(200);
    check("t1_issue_lat", cv_cyc - push_cyc, 32'd2);
    check("t1_cv_width", cv_cycles - cvb, 32'd1);
    check("t1_out_after_done", ov_rise_cyc - done_cyc, 32'd1);

    // 2: bypass byte.
    core_override = -1;
    cvb = cv_cycles;
    push_byte(8'h20, 1'b0, 20);
    wait_drain(200);
    check("t2_bypass_lat", ov_rise_cyc - push_cyc, 32'd2);
    check("t2_no_core", cv_cycles - cvb, 32'd0);

    // 3: back-pressure fills the FIFO behind the stalled output.
    ready_mode = 0; core_lat = 1;
    idle_cycles(2);
    oc = out_count; acc = 0;
    bus.in_valid = 1'b1; bus.in_dec = 1'b0; bus.in_data = 8'h42;
    for (int i = 0; i < 4 * int'(DEPTH) + 12; i++) begin
      #4;
      if (bus.in_ready) begin
        expect_push(bus.in_data, 1'b0);
        acc++;
      end
      @(negedge clk);
      bus.in_data = 8'(8'h42 + acc);
    end
    bus.in_valid = 1'b0;
    #4;
    check("t3_accepted", acc, DEPTH + 1);
    check("t3_in_ready_low", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    ready_mode = 1;
    wait_drain(400);
    check("t3_out_count", out_count - oc, DEPTH + 1);

    // 4: silent core forces a timeout; a late done is ignored.
    core_mute = 1'b1;
    push_byte(8'h43, 1'b0, 20);
    wait_drain(TIMEOUT + 60);
    check("t4_wait_cycles", ov_rise_cyc - cv_cyc, TIMEOUT + 1);
    check("t4_err_timeout", 32'(err_timeout), 32'd1);
    oc = out_count;
    inj_dout = 8'd3; inj_req_cnt++;
    idle_cycles(6);
    check("t4_late_done_out", out_count - oc, 32'd0);
    check("t4_late_done_busy", 32'(busy), 32'd0);
    check("t4_err_range_clear", 32'(err_range), 32'd0);
    core_mute = 1'b0;

    // 5: out-of-range result, then a normal character.
    core_override = 30; core_lat = 2;
    push_byte(8'h42, 1'b1, 20);
    wait_drain(200);
    check("t5_err_range", 32'(err_range), 32'd1);
    core_override = -1;
    push_byte(8'h4B, 1'b1, 20);
    wait_drain(200);
    check("t5_err_range_sticky", 32'(err_range), 32'd1);
    check("t5_err_timeout_sticky", 32'(err_timeout), 32'd1);

    // 6: reset while waiting on the core with bytes still queued.
    core_mute = 1'b1;
    push_byte(8'h45, 1'b0, 20);
    push_byte(8'h46, 1'b0, 20);
    push_byte(8'h21, 1'b0, 20);
    idle_cycles(2);
    reset = 1'b1;
    #1;
    check("t6_reset_outs",
          {bus.in_ready, bus.out_valid, bus.core_valid, bus.core_dec, bus.core_din,
           bus.out_data, busy, err_timeout, err_range}, 32'd0);
    idle_cycles(2);
    reset = 1'b0;
    #4;
    check("t6_release", {bus.in_ready, busy, bus.out_valid}, 3'b100);
    @(negedge clk);
    oc = out_count;
    inj_dout = 8'd5; inj_req_cnt++;
    idle_cycles(6);
    check("t6_stale_done_out", out_count - oc, 32'd0);
    check("t6_stale_done_errs", {err_timeout, err_range, busy}, 3'b000);
    core_mute = 1'b0; core_lat = 1;
    push_byte(8'h48, 1'b0, 20);
    wait_drain(200);

    // Random streams with random core latency and downstream stalls.
    ready_mode = 2;
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: b = 8'(8'h41 + $urandom_range(0, 25));
        5, 6:          b = 8'(8'h61 + $urandom_range(0, 25));
        7:             b = 8'h20;
        8:             b = 8'($urandom_range(0, 255));
        default:       b = 8'(8'h30 + $urandom_range(0, 9));
      endcase
      core_lat = int'($urandom_range(1, 6));
      push_byte(b, 1'($urandom_range(0, 1)), 200);
      idle_cycles(int'($urandom_range(0, 2)));
    end
    wait_drain(3000);
    check("rand_errs", {err_timeout, err_range}, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute guard against a stuck run.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "simulation time limit");
  end

endmodule
